// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, frame constants, parity helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

    // 3-bit state encoding of the transmit FSM.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_WAIT   = S_WAIT,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity makes the total count of ones even; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
// Latency: bit_tick is a decode of the registered count; clear takes effect on the next edge.
// Backpressure: none; free-running unless cleared.
// Ports: clock, resetn (sync, active-low), clear (restart the period), bit_tick (last cycle of period).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic bit_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// Drains bytes from the packet FIFO and serialises them as UART frames (start, 8 data LSB first, opt. parity, 1-2 stop).
// Latency: fetch condition seen in IDLE at edge E0 -> read strobe after E0 -> tx falls after E2.
// Backpressure: waits on fifo_empty / tx_enable; frames in flight always complete unless soft_reset aborts them.
// Ports: clock, resetn, soft_reset, tx_enable, fifo_empty, fifo_data[7:0] in; fifo_read_enb, tx, busy, byte_done out.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       soft_reset,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_enb,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    tx_state_t  state, state_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_q, data_n;
    logic       tx_n;
    logic       bit_tick;
    logic       baud_clear;
    logic       last_stop;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    // bit_idx doubles as the stop-bit counter while in STOP.
    assign last_stop  = (state == ST_STOP) && bit_tick && (bit_idx == 3'(STOP_BITS - 1));
    assign byte_done  = last_stop;
    // Every state change restarts the bit period so each state gets full bit lengths.
    assign baud_clear = soft_reset || (state_n != state);

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = data_q;
        case (state)
            ST_IDLE:   if (tx_enable && !fifo_empty) state_n = ST_FETCH;
            ST_FETCH:  state_n = ST_WAIT;
            ST_WAIT: begin
                // FIFO output is registered: the byte is valid only in this cycle.
                state_n = ST_START;
                shift_n = fifo_data;
                data_n  = fifo_data;
            end
            ST_START:  if (bit_tick) state_n = ST_DATA;
            ST_DATA: begin
                if (bit_tick) begin
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: if (bit_tick) state_n = ST_STOP;
            ST_STOP: begin
                if (bit_tick) begin
                    bit_idx_n = bit_idx + 3'd1;
                    if (last_stop) begin
                        state_n = (tx_enable && !fifo_empty) ? ST_FETCH : ST_IDLE;
                    end
                end
            end
            default:   state_n = ST_IDLE;
        endcase

        if (state_n != state) bit_idx_n = '0;

        // tx is registered from the next-state decode so the line level lines up with the state.
        tx_n = IDLE_LEVEL;
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
            ST_PARITY: tx_n = parity_bit(data_q, PARITY_ODD != 0);
            default:   tx_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            state         <= ST_IDLE;
            bit_idx       <= '0;
            shift         <= '0;
            data_q        <= '0;
            tx            <= IDLE_LEVEL;
            fifo_read_enb <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            bit_idx       <= bit_idx_n;
            shift         <= shift_n;
            data_q        <= data_n;
            tx            <= tx_n;
            fifo_read_enb <= (state_n == ST_FETCH);
            busy          <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx: four instances (no parity, even parity, odd parity, two stop bits), CLKS_PER_BIT=4.
// Each instance is fed by a small registered-output FIFO model; line levels are checked cycle by cycle.
module tb_uart_fifo_tx;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic [3:0] ten;
    logic [3:0] fe;
    logic [7:0] fd [4];
    logic [3:0] rd;
    logic [3:0] txs;
    logic [3:0] bsy;
    logic [3:0] bd;

    logic [7:0] mem [4][16];
    int         head [4] = '{default: 0};
    int         tail [4] = '{default: 0};
    int         rd_cnt [4] = '{default: 0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .tx_enable(ten[0]),
        .fifo_empty(fe[0]), .fifo_data(fd[0]), .fifo_read_enb(rd[0]), .tx(txs[0]),
        .busy(bsy[0]), .byte_done(bd[0]));

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .tx_enable(ten[1]),
        .fifo_empty(fe[1]), .fifo_data(fd[1]), .fifo_read_enb(rd[1]), .tx(txs[1]),
        .busy(bsy[1]), .byte_done(bd[1]));

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .tx_enable(ten[2]),
        .fifo_empty(fe[2]), .fifo_data(fd[2]), .fifo_read_enb(rd[2]), .tx(txs[2]),
        .busy(bsy[2]), .byte_done(bd[2]));

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .tx_enable(ten[3]),
        .fifo_empty(fe[3]), .fifo_data(fd[3]), .fifo_read_enb(rd[3]), .tx(txs[3]),
        .busy(bsy[3]), .byte_done(bd[3]));

    // FIFO models: data_out registered, valid the cycle after read_enb.
    always_comb begin
        for (int k = 0; k < 4; k++) fe[k] = (head[k] == tail[k]);
    end

    always @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (rd[k]) rd_cnt[k] <= rd_cnt[k] + 1;
            if (rd[k] && head[k] != tail[k]) begin
                fd[k]   <= mem[k][head[k] % 16];
                head[k] <= head[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][tail[k] % 16] = d;
        tail[k] = tail[k] + 1;
    endtask

    // Returns with the sample point in the FETCH cycle (read strobe high).
    task automatic wait_read(input int k, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (rd[k]) seen = 1;
        end
        chk({tag, "_read_seen"}, 32'(seen), 32'd1);
    endtask

    // Starts at the FETCH sample; ends at the sample of the last stop cycle.
    task automatic run_frame(input int k, input logic [7:0] d, input int has_par,
                             input logic par, input int nstop, input string tag);
        int         nseg;
        int         ok;
        int         bd_n;
        logic       exp;
        logic       last_bd;
        logic [7:0] dv;
        dv = d;
        bd_n = 0;
        last_bd = 1'b0;
        tick();
        chk({tag, "_wait_tx"}, 32'(txs[k]), 32'd1);
        chk({tag, "_wait_busy"}, 32'(bsy[k]), 32'd1);
        nseg = 1 + 8 + has_par + nstop;
        for (int s = 0; s < nseg; s++) begin
            if (s == 0)                      exp = 1'b0;
            else if (s <= 8)                 exp = dv[s-1];
            else if (has_par != 0 && s == 9) exp = par;
            else                             exp = 1'b1;
            ok = 0;
            for (int c = 0; c < CPB; c++) begin
                tick();
                if (txs[k] === exp) ok++;
                bd_n += int'(bd[k]);
                if (s == nseg - 1 && c == CPB - 1) last_bd = bd[k];
                if (s == nseg - 1 && c == CPB - 1 && nstop == 2) break;
            end
            chk($sformatf("%s_seg%0d", tag, s), 32'(ok), 32'(CPB));
        end
        chk({tag, "_bd_last"}, 32'(last_bd), 32'd1);
        chk({tag, "_bd_count"}, 32'(bd_n), 32'd1);
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        soft_reset = 1'b0;
        ten        = 4'hF;
        push(0, 8'hA5);

        // Reset held with a non-empty FIFO and tx_enable high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", 32'(txs[0]), 32'd1);
            chk("rst_rd", 32'(rd[0]), 32'd0);
            chk("rst_busy", 32'(bsy[0]), 32'd0);
        end
        resetn = 1'b1;

        // Plain 8N1 frame of A5: line 0,1,0,1,0,0,1,0,1 then stop.
        wait_read(0, "a5");
        run_frame(0, 8'hA5, 0, 1'b0, 1, "a5");
        for (int i = 0; i < 5; i++) tick();
        chk("a5_reads", 32'(rd_cnt[0]), 32'd1);
        chk("a5_idle_busy", 32'(bsy[0]), 32'd0);

        // Even parity of 07 (three ones) -> 1; odd parity -> 0.
        push(1, 8'h07);
        wait_read(1, "par_even");
        run_frame(1, 8'h07, 1, 1'b1, 1, "par_even");
        push(2, 8'h07);
        wait_read(2, "par_odd");
        run_frame(2, 8'h07, 1, 1'b0, 1, "par_odd");

        // Back-to-back frames with two stop bits: FETCH follows the last stop cycle directly.
        push(3, 8'h00);
        push(3, 8'hFF);
        push(3, 8'h3C);
        wait_read(3, "b2b0");
        run_frame(3, 8'h00, 0, 1'b0, 2, "b2b0");
        tick();
        chk("b2b1_read", 32'(rd[3]), 32'd1);
        run_frame(3, 8'hFF, 0, 1'b0, 2, "b2b1");
        tick();
        chk("b2b2_read", 32'(rd[3]), 32'd1);
        run_frame(3, 8'h3C, 0, 1'b0, 2, "b2b2");
        for (int i = 0; i < 5; i++) tick();
        chk("b2b_reads", 32'(rd_cnt[3]), 32'd3);

        // Abort during data bit 3 of 52 (bit3 = 0), then C3 goes out whole.
        push(0, 8'h52);
        push(0, 8'hC3);
        wait_read(0, "srst");
        for (int i = 0; i < 2 + 4 + 12 + 1; i++) tick();
        chk("srst_in_bit3", 32'(txs[0]), 32'd0);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        chk("srst_tx", 32'(txs[0]), 32'd1);
        chk("srst_busy", 32'(bsy[0]), 32'd0);
        wait_read(0, "after_srst");
        run_frame(0, 8'hC3, 0, 1'b0, 1, "after_srst");

        // Empty FIFO with tx_enable high: never a read.
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n += int'(rd[0]);
        end
        chk("empty_no_read", 32'(n), 32'd0);
        chk("empty_reads_total", 32'(rd_cnt[0]), 32'd3);

        // tx_enable dropped during a frame: frame of 81 (even parity 0) completes, 42 stays queued.
        push(1, 8'h81);
        push(1, 8'h42);
        wait_read(1, "ten_drop");
        ten[1] = 1'b0;
        run_frame(1, 8'h81, 1, 1'b0, 1, "ten_drop");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(rd[1]);
        end
        chk("ten_drop_no_read", 32'(n), 32'd0);
        chk("ten_drop_busy", 32'(bsy[1]), 32'd0);
        chk("ten_drop_left", 32'(fe[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
